// File: rtl/divider_8bit_seq.sv
// Multi-cycle unsigned restoring divider.
// One subtract-and-shift step is performed per clock while in CALC; a zero
// divisor bypasses the iterations and reports an all-ones quotient with the
// dividend as remainder.
//
// Handshake: start is sampled only while idle (busy=0, done=0). The rising
// edge that samples start=1 in IDLE captures dividend/divisor; start at any
// other time is ignored and not queued. done is a one-cycle pulse during which
// quotient/remainder/div_by_zero are valid; those outputs then hold until the
// next completed operation or reset.
module divider_8bit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvs_reg;

    logic [WIDTH:0]   t_val;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] next_r;
    logic [WIDTH-1:0] next_q;

    assign busy = (state == CALC);
    assign done = (state == DONE);

    // One restoring step: shift {R,Q} left, trial-subtract the divisor in
    // WIDTH+1 bits so a partial remainder with its MSB set cannot overflow.
    always_comb begin
        t_val  = {r_reg, q_reg[WIDTH-1]};
        diff   = t_val - {1'b0, dvs_reg};
        ge     = (t_val >= {1'b0, dvs_reg});
        next_r = ge ? diff[WIDTH-1:0] : t_val[WIDTH-1:0];
        next_q = {q_reg[WIDTH-2:0], ge};
    end

    // Control FSM and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            dvs_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvs_reg <= divisor;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            r_reg <= '0;
                            q_reg <= dividend;
                            count <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_reg <= next_r;
                    q_reg <= next_q;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        quotient    <= next_q;
                        remainder   <= next_r;
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_8bit_seq.sv
// Bench for divider_8bit_seq: directed vector table, multi-cycle corner
// sequences (reset, handshake abuse, reset mid-operation) and random operands
// checked against an arithmetic reference model.
module tb_divider_8bit_seq;

    localparam int W = 8;
    localparam int TIMEOUT = 50;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    divider_8bit_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: plain unsigned arithmetic
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    // Issue one division from IDLE; report results, latency to done (edges
    // after the accepting edge), busy cycles, pulse width and output holding.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output int lat, output int busy_n,
                           output logic pulse_ok, output logic held_ok);
        logic [W-1:0] pq, pr;
        pq = quotient;
        pr = remainder;
        held_ok = 1'b1;
        busy_n = 0;
        lat = 0;
        dividend = a;
        divisor = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        dividend = $urandom_range(0, 255);
        divisor = $urandom_range(0, 255);
        while (!done && lat < TIMEOUT) begin
            if (busy) busy_n++;
            if (quotient !== pq || remainder !== pr) held_ok = 1'b0;
            tick();
            lat++;
        end
        q = quotient;
        r = remainder;
        dz = div_by_zero;
        tick();
        pulse_ok = !done && !busy;
    endtask

    task automatic do_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        logic [W-1:0] q, r;
        logic dz, pulse_ok, held_ok;
        int lat, bn;
        run_div(a, b, q, r, dz, lat, bn, pulse_ok, held_ok);
        check({tag, " quotient"}, q, eq);
        check({tag, " remainder"}, r, er);
        check({tag, " div_by_zero"}, dz, edz);
        check({tag, " latency"}, lat, edz ? 0 : W);
        check({tag, " busy_cycles"}, bn, edz ? 0 : W);
        check({tag, " done_pulse"}, pulse_ok, 1);
        check({tag, " held"}, held_ok, 1);
    endtask

    initial begin
        logic [W-1:0] eq, er, q, r, ra, rb;
        logic edz, dz, pulse_ok, held_ok;
        int lat, bn, done_cnt;

        vecs.push_back('{8'd200, 8'd7,   8'd28,  8'd4,    1'b0});
        vecs.push_back('{8'h0F,  8'h01,  8'h0F,  8'h00,   1'b0});
        vecs.push_back('{8'hFF,  8'hFF,  8'h01,  8'h00,   1'b0});
        vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5,    1'b0});
        vecs.push_back('{8'hFF,  8'h01,  8'hFF,  8'h00,   1'b0});
        vecs.push_back('{8'd0,   8'd3,   8'd0,   8'd0,    1'b0});
        vecs.push_back('{8'h0A,  8'h00,  8'hFF,  8'h0A,   1'b1});
        vecs.push_back('{8'd9,   8'd2,   8'd4,   8'd1,    1'b0});
        vecs.push_back('{8'hFE,  8'hFF,  8'h00,  8'hFE,   1'b0});
        vecs.push_back('{8'h81,  8'h80,  8'h01,  8'h01,   1'b0});

        // reset
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        rst_n = 1'b1;
        tick();

        // directed table, issued back-to-back in the cycle after each done
        foreach (vecs[i]) begin
            do_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        // start pulsed mid-CALC with altered operands: ignored, one done only
        dividend = 8'd100;
        divisor = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        dividend = 8'd50;
        divisor = 8'd5;
        tick();
        start = 1'b0;
        dividend = 8'd77;
        divisor = 8'd0;
        done_cnt = 0;
        q = '0;
        r = '0;
        for (int c = 0; c < 3 * W; c++) begin
            if (done) begin
                done_cnt++;
                q = quotient;
                r = remainder;
            end
            tick();
        end
        check("ignored_start done_count", done_cnt, 1);
        check("ignored_start quotient", q, 33);
        check("ignored_start remainder", r, 1);

        // reset asserted at edge k+4 of 200/7
        dividend = 8'd200;
        divisor = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset quotient", quotient, 0);
        check("midreset remainder", remainder, 0);
        check("midreset div_by_zero", div_by_zero, 0);
        tick();
        check("midreset stays_idle", busy | done, 0);
        do_vec("after_reset 9/2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0);

        // random operands against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            ra = $urandom_range(0, 255);
            rb = ($urandom_range(0, 9) == 0) ? 8'd0 : $urandom_range(1, 255);
            model(ra, rb, eq, er, edz);
            run_div(ra, rb, q, r, dz, lat, bn, pulse_ok, held_ok);
            check($sformatf("rand %0d/%0d q", ra, rb), q, eq);
            check($sformatf("rand %0d/%0d r", ra, rb), r, er);
            check($sformatf("rand %0d/%0d dz", ra, rb), dz, edz);
            check($sformatf("rand %0d/%0d lat", ra, rb), lat, edz ? 0 : W);
            check($sformatf("rand %0d/%0d pulse", ra, rb), pulse_ok, 1);
            if ($urandom_range(0, 3) == 0) tick();
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
